// File: rtl/sample_timer_sequencer.sv
// sample_timer_sequencer
//   Control FSM wrapped around a 32-bit preset down-counter timer. The timer
//   paces periodic sensor measurements: every expiry starts one measurement
//   through a start/done handshake. Each result is compared with the last
//   reported value, and a one-cycle CPU interrupt is raised when the absolute
//   change exceeds a threshold.
//
//   Build option: define SAMPLE_SEQ_TIMEOUT_EN to enable a measurement
//   watchdog of TIMEOUT_CYCLES clock cycles. It flags Error_o and abandons the
//   measurement. When the macro is undefined, MEASURE waits indefinitely and
//   Error_o is tied to 0.
//
// Ports
//   Clk_i            clock, rising edge
//   Reset_i          synchronous active-high reset
//   Enable_i         1 = periodic sampling, 0 = hold in DISABLED
//   ParamPeriod_i    timer reload value P
//   Threshold_i      unsigned change threshold
//   TimerPreset_o    preset strobe to the timer (DISABLED and RELOAD)
//   TimerPresetVal_o combinational copy of ParamPeriod_i
//   TimerZero_i      timer zero flag
//   MeasStart_o      one-cycle measurement start pulse
//   MeasDone_i       measurement complete; MeasValue_i valid in same cycle
//   MeasValue_i      measurement result
//   SensorValue_o    last stored (reported) value
//   CpuIntr_o        one-cycle interrupt pulse during RELOAD
//   Error_o          one-cycle timeout pulse during RELOAD
module sample_timer_sequencer #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  Clk_i,
    input  logic                  Reset_i,
    input  logic                  Enable_i,
    input  logic [31:0]           ParamPeriod_i,
    input  logic [DATA_WIDTH-1:0] Threshold_i,
    output logic                  TimerPreset_o,
    output logic [31:0]           TimerPresetVal_o,
    input  logic                  TimerZero_i,
    output logic                  MeasStart_o,
    input  logic                  MeasDone_i,
    input  logic [DATA_WIDTH-1:0] MeasValue_i,
    output logic [DATA_WIDTH-1:0] SensorValue_o,
    output logic                  CpuIntr_o,
    output logic                  Error_o
);

    typedef enum logic [2:0] {
        ST_DISABLED,
        ST_WAIT,
        ST_START,
        ST_MEASURE,
        ST_RELOAD
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sensor_q, sensor_d;
    logic                  valid_q, valid_d;
    logic                  intr_q, intr_d;
    logic [DATA_WIDTH-1:0] diff;
    logic                  capture;

`ifdef SAMPLE_SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]           cnt_q, cnt_d;
    logic                  err_q, err_d;
`else
    logic [15:0]           timeout_unused;
    assign timeout_unused = 16'(TIMEOUT_CYCLES);
`endif

    // Unsigned max minus min, so the difference never wraps.
    always_comb begin
        if (MeasValue_i >= sensor_q) diff = MeasValue_i - sensor_q;
        else                         diff = sensor_q - MeasValue_i;
    end

    // The first result after (re)enable is always reported.
    assign capture = !valid_q || (diff > Threshold_i);

    always_comb begin
        state_d  = state_q;
        sensor_d = sensor_q;
        valid_d  = valid_q;
        intr_d   = 1'b0;
`ifdef SAMPLE_SEQ_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        if (state_q == ST_DISABLED) valid_d = 1'b0;

        if (!Enable_i) begin
            // Dropping enable abandons any pending measurement silently.
            state_d = ST_DISABLED;
        end else begin
            case (state_q)
                ST_DISABLED: state_d = ST_WAIT;
                ST_WAIT:     if (TimerZero_i) state_d = ST_START;
                ST_START: begin
                    state_d = ST_MEASURE;
`ifdef SAMPLE_SEQ_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
                ST_MEASURE: begin
                    if (MeasDone_i) begin
                        state_d = ST_RELOAD;
                        if (capture) begin
                            sensor_d = MeasValue_i;
                            valid_d  = 1'b1;
                            intr_d   = 1'b1;
                        end
                    end
`ifdef SAMPLE_SEQ_TIMEOUT_EN
                    // Done in the limit cycle takes precedence over timeout.
                    else if (cnt_q == TO_LAST) begin
                        state_d = ST_RELOAD;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
`endif
                end
                ST_RELOAD:   state_d = ST_WAIT;
                default:     state_d = ST_DISABLED;
            endcase
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q  <= ST_DISABLED;
            sensor_q <= '0;
            valid_q  <= 1'b0;
            intr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sensor_q <= sensor_d;
            valid_q  <= valid_d;
            intr_q   <= intr_d;
        end
    end

`ifdef SAMPLE_SEQ_TIMEOUT_EN
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign Error_o = err_q;
`else
    assign Error_o = 1'b0;
`endif

    assign TimerPreset_o    = (state_q == ST_DISABLED) || (state_q == ST_RELOAD);
    assign TimerPresetVal_o = ParamPeriod_i;
    assign MeasStart_o      = (state_q == ST_START);
    assign SensorValue_o    = sensor_q;
    assign CpuIntr_o        = intr_q;

endmodule

// File: tb/tb_sample_timer_sequencer.sv
// Directed bench for sample_timer_sequencer with a behavioural preset
// down-counter attached to the timer interface.
module tb_sample_timer_sequencer;

    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [31:0]   period;
    logic [DW-1:0] thr;
    logic          tpreset;
    logic [31:0]   tpresetval;
    logic          tzero;
    logic          mstart;
    logic          mdone;
    logic [DW-1:0] mval;
    logic [DW-1:0] sensor;
    logic          intr;
    logic          err;

    int tests = 0;
    int fails = 0;

    logic [31:0] tval = '0;

    always #5 clk = ~clk;

    // Timer model: loads on preset, otherwise counts down and stops at zero.
    always @(posedge clk) begin
        if (tpreset)        tval <= tpresetval;
        else if (tval != 0) tval <= tval - 32'd1;
    end
    assign tzero = (tval == 32'd0);

    sample_timer_sequencer #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .Clk_i            (clk),
        .Reset_i          (rst),
        .Enable_i         (en),
        .ParamPeriod_i    (period),
        .Threshold_i      (thr),
        .TimerPreset_o    (tpreset),
        .TimerPresetVal_o (tpresetval),
        .TimerZero_i      (tzero),
        .MeasStart_o      (mstart),
        .MeasDone_i       (mdone),
        .MeasValue_i      (mval),
        .SensorValue_o    (sensor),
        .CpuIntr_o        (intr),
        .Error_o          (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance until the START cycle, bounded.
    task automatic wait_start();
        int n = 0;
        while (mstart !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("start_seen", {31'd0, mstart}, 32'd1);
    endtask

    // Called in the first MEASURE cycle; done arrives after lat cycles.
    // Returns in the RELOAD cycle after checking interrupt and stored value.
    task automatic do_meas(input string tag, input logic [DW-1:0] v, input int lat,
                           input logic exp_intr, input logic [DW-1:0] exp_val);
        for (int i = 0; i < lat; i++) tick();
        mdone = 1'b1;
        mval  = v;
        tick();
        mdone = 1'b0;
        check({tag, "_intr"},   {31'd0, intr},    {31'd0, exp_intr});
        check({tag, "_preset"}, {31'd0, tpreset}, 32'd1);
        check({tag, "_err"},    {31'd0, err},     32'd0);
        check({tag, "_value"},  {16'd0, sensor},  {16'd0, exp_val});
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; period = 32'd3; thr = 16'd10;
        mdone = 1'b0; mval = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_preset", {31'd0, tpreset}, 32'd1);
        check("rst_start",  {31'd0, mstart},  32'd0);
        check("rst_intr",   {31'd0, intr},    32'd0);
        check("rst_err",    {31'd0, err},     32'd0);
        check("rst_value",  {16'd0, sensor},  32'd0);
        check("presetval",  tpresetval,       32'd3);

        // Enable with P=3: four WAIT cycles, then START.
        en = 1'b1;
        tick();
        check("wait_preset", {31'd0, tpreset}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("wait_nostart", {31'd0, mstart}, 32'd0);
            tick();
        end
        check("start_pulse", {31'd0, mstart}, 32'd1);
        // Done during START must be ignored.
        mdone = 1'b1; mval = 16'd7;
        tick();
        mdone = 1'b0;
        check("start_once", {31'd0, mstart}, 32'd0);

        do_meas("first", 16'd100, 2, 1'b1, 16'd100);
        tick();
        check("intr_single", {31'd0, intr}, 32'd0);

        // Within threshold: no report.
        wait_start(); tick();
        do_meas("d5", 16'd105, 1, 1'b0, 16'd100);
        // d=11 > 10.
        wait_start(); tick();
        do_meas("d11", 16'd111, 3, 1'b1, 16'd111);
        wait_start(); tick();
        do_meas("max", 16'hFFFF, 1, 1'b1, 16'hFFFF);

        // Full-scale difference with zero threshold, then d=0 is not > 0.
        thr = 16'd0;
        wait_start(); tick();
        do_meas("zero", 16'd0, 1, 1'b1, 16'd0);
        wait_start(); tick();
        do_meas("eq", 16'd0, 1, 1'b0, 16'd0);

        // Period change lands at the next preset: P=0 gives one WAIT cycle.
        wait_start(); tick();
        period = 32'd0;
        do_meas("p0", 16'd40, 1, 1'b1, 16'd40);
        tick();
        check("p0_wait", {31'd0, mstart}, 32'd0);
        tick();
        check("p0_start", {31'd0, mstart}, 32'd1);

        // Abandon a measurement by dropping enable.
        tick();
        en = 1'b0;
        tick();
        check("abandon_preset", {31'd0, tpreset}, 32'd1);
        tick();
        mdone = 1'b1; mval = 16'd500;
        tick();
        mdone = 1'b0;
        check("abandon_intr",  {31'd0, intr},   32'd0);
        check("abandon_value", {16'd0, sensor}, 32'd40);
        tick();
        check("abandon_intr2", {31'd0, intr},   32'd0);

        // Re-enable: first sample reports even though d can never exceed max.
        thr = 16'hFFFF;
        en  = 1'b1;
        wait_start(); tick();
        do_meas("reenable", 16'd5, 1, 1'b1, 16'd5);

        // Measurement never completes.
        wait_start(); tick();
`ifdef SAMPLE_SEQ_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            check("to_meas_err",    {31'd0, err},     32'd0);
            check("to_meas_preset", {31'd0, tpreset}, 32'd0);
            tick();
        end
        check("to_err",    {31'd0, err},     32'd1);
        check("to_intr",   {31'd0, intr},    32'd0);
        check("to_preset", {31'd0, tpreset}, 32'd1);
        check("to_value",  {16'd0, sensor},  32'd5);
        tick();
        check("to_err_end", {31'd0, err}, 32'd0);
        // Done in the limit cycle wins over the timeout.
        wait_start(); tick();
        thr = 16'd0;
        do_meas("to_race", 16'd9, 7, 1'b1, 16'd9);
`else
        for (int i = 0; i < 20; i++) begin
            check("hold_err",    {31'd0, err},     32'd0);
            check("hold_preset", {31'd0, tpreset}, 32'd0);
            check("hold_start",  {31'd0, mstart},  32'd0);
            tick();
        end
        thr = 16'd0;
        do_meas("late_done", 16'd9, 0, 1'b1, 16'd9);
`endif
        // Sampling resumes.
        wait_start();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
